mc_ctrl: RTL

Multi-cycle control FSM that sequences the MIPS fetch/decode/execute datapath built around the instruction fetch unit, register file, ALU and data memory. It issues the PC and IR write strobes and the next-PC select (same 4-bit encoding the fetch unit uses), and steers register-file, ALU and memory muxes per state. It replaces single-cycle control, so one instruction takes 2–5 cycles. Data-memory accesses wait on a ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 90 +++++++++
 rtl/mc_decode.sv | 34 +++
 rtl/mc_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcode/funct
// constants, state and instruction-class encodings, and mux select codes.
package mc_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP     = 4'd0,
    CLS_ADDU    = 4'd1,
    CLS_SUBU    = 4'd2,
    CLS_ORI     = 4'd3,
    CLS_LUI     = 4'd4,
    CLS_LW      = 4'd5,
    CLS_SW      = 4'd6,
    CLS_BEQ     = 4'd7,
    CLS_J       = 4'd8,
    CLS_JAL     = 4'd9,
    CLS_JR      = 4'd10,
    CLS_ILLEGAL = 4'd11
  } cls_e;

  // Next-PC source codes (shared with the fetch unit); widened at use site
  localparam int NPC_PC4  = 0;
  localparam int NPC_BR   = 1;
  localparam int NPC_JUMP = 2;
  localparam int NPC_JR   = 3;

  localparam logic [1:0] WA_RT = 2'd0;
  localparam logic [1:0] WA_RD = 2'd1;
  localparam logic [1:0] WA_RA = 2'd2;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_LINK = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HI   = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
  } alu_ctrl_t;

  // ALU steering for a class; held unchanged from EXEC through MEM and WB
  function automatic alu_ctrl_t alu_ctrl_of(input cls_e cls);
    alu_ctrl_t c;
    c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_ADD};
    case (cls)
      CLS_ADDU: c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_ADD};
      CLS_SUBU: c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_SUB};
      CLS_BEQ:  c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_SUB};
      CLS_ORI:  c = '{alu_src: 1'b1, ext_op: EXT_ZERO, alu_op: ALU_OR};
      CLS_LUI:  c = '{alu_src: 1'b1, ext_op: EXT_HI,   alu_op: ALU_OR};
      CLS_LW:   c = '{alu_src: 1'b1, ext_op: EXT_SIGN, alu_op: ALU_ADD};
      CLS_SW:   c = '{alu_src: 1'b1, ext_op: EXT_SIGN, alu_op: ALU_ADD};
      default:  c = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_ADD};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_e       cls
);

  // Map the instruction fields to a class; anything unrecognised is ILLEGAL
  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_NOP:  cls = CLS_NOP;
          FN_ADDU: cls = CLS_ADDU;
          FN_SUBU: cls = CLS_SUBU;
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Build option: define MC_CTRL_ILLEGAL_HALT_EN to trap illegal instructions
// in HALT; otherwise they retire as NOPs and HALT is unreachable.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int NPC_SEL_W = 4,
  parameter int RETIRE_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 equal,
  input  logic                 dm_ready,
  output logic                 pc_we,
  output logic                 ir_we,
  output logic [NPC_SEL_W-1:0] npc_sel,
  output logic                 rf_we,
  output logic [1:0]           rf_wa_sel,
  output logic [1:0]           rf_wd_sel,
  output logic                 alu_src,
  output logic [1:0]           ext_op,
  output logic [2:0]           alu_op,
  output logic                 dm_re,
  output logic                 dm_we,
  output logic [2:0]           state,
  output logic [RETIRE_W-1:0]  retired,
  output logic                 halted
);

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  cls_e                dec_cls;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic pc_we_s, ir_we_s, rf_we_s, dm_re_s, dm_we_s;
  alu_ctrl_t alu_s;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (dec_cls)
  );

  // State, latched class and retire counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_NOP;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, class latch and retire-count logic
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          CLS_NOP, CLS_J, CLS_JAL, CLS_JR: state_d = ST_FETCH;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
          CLS_ILLEGAL: state_d = ST_HALT;
`else
          CLS_ILLEGAL: state_d = ST_FETCH;
`endif
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LW, CLS_SW:                     state_d = ST_MEM;
          CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI: state_d = ST_WB;
          default:                            state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dm_ready) begin
          state_d = (cls_q == CLS_SW) ? ST_FETCH : ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB:   state_d = ST_FETCH;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_FETCH;
    endcase
    // FETCH always leaves, so any arrival in FETCH completes an instruction
    if (state_d == ST_FETCH) begin
      retired_d = retired_q + RETIRE_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Per-state datapath controls; DECODE uses the live decode, later states the latched class
  always_comb begin
    pc_we_s   = 1'b0;
    ir_we_s   = 1'b0;
    rf_we_s   = 1'b0;
    dm_re_s   = 1'b0;
    dm_we_s   = 1'b0;
    npc_sel   = NPC_SEL_W'(NPC_PC4);
    rf_wa_sel = WA_RT;
    rf_wd_sel = WD_ALU;
    alu_s     = '{alu_src: 1'b0, ext_op: EXT_ZERO, alu_op: ALU_ADD};
    case (state_q)
      ST_FETCH: begin
        ir_we_s = 1'b1;
        pc_we_s = 1'b1;
        npc_sel = NPC_SEL_W'(NPC_PC4);
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_J: begin
            pc_we_s = 1'b1;
            npc_sel = NPC_SEL_W'(NPC_JUMP);
          end
          CLS_JAL: begin
            pc_we_s   = 1'b1;
            npc_sel   = NPC_SEL_W'(NPC_JUMP);
            rf_we_s   = 1'b1;
            rf_wa_sel = WA_RA;
            rf_wd_sel = WD_LINK;
          end
          CLS_JR: begin
            pc_we_s = 1'b1;
            npc_sel = NPC_SEL_W'(NPC_JR);
          end
          default: pc_we_s = 1'b0;
        endcase
      end
      ST_EXEC: begin
        alu_s = alu_ctrl_of(cls_q);
        if (cls_q == CLS_BEQ) begin
          npc_sel = NPC_SEL_W'(NPC_BR);
          pc_we_s = equal;
        end else begin
          pc_we_s = 1'b0;
        end
      end
      ST_MEM: begin
        alu_s   = alu_ctrl_of(cls_q);
        dm_re_s = (cls_q == CLS_LW);
        dm_we_s = (cls_q == CLS_SW);
      end
      ST_WB: begin
        alu_s   = alu_ctrl_of(cls_q);
        rf_we_s = 1'b1;
        case (cls_q)
          CLS_ADDU, CLS_SUBU: begin
            rf_wa_sel = WA_RD;
            rf_wd_sel = WD_ALU;
          end
          CLS_LW: begin
            rf_wa_sel = WA_RT;
            rf_wd_sel = WD_MEM;
          end
          default: begin
            rf_wa_sel = WA_RT;
            rf_wd_sel = WD_ALU;
          end
        endcase
      end
      default: pc_we_s = 1'b0;
    endcase
  end

  // Strobes are suppressed in any reset cycle so an interrupted instruction never half-commits
  assign pc_we   = pc_we_s & ~reset;
  assign ir_we   = ir_we_s & ~reset;
  assign rf_we   = rf_we_s & ~reset;
  assign dm_re   = dm_re_s & ~reset;
  assign dm_we   = dm_we_s & ~reset;
  assign alu_src = alu_s.alu_src;
  assign ext_op  = alu_s.ext_op;
  assign alu_op  = alu_s.alu_op;
  assign state   = state_q;
  assign retired = retired_q;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
  assign halted  = (state_q == ST_HALT);
`else
  assign halted  = 1'b0;
`endif

endmodule
